// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: funct3 codes, FSM states, constants.
// Imported by the mul/div unit and its bench.
package riscv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the core's operand muxes
// and the mul/div unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: magnitude shift datapath
// shared by shift-add multiply and restoring divide.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  typedef logic [WIDTH-1:0] word_t;
  localparam word_t SMIN = word_t'(INT_MIN);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    f3;
  logic          neg;
  word_t         hi;
  word_t         lo;
  word_t         mb;
  logic          busy_q;
  logic          done_q;
  word_t         res_q;

  logic  a_sgn;
  logic  b_sgn;
  logic  sa;
  logic  sb;
  word_t mag_a;
  word_t mag_b;
  logic  sign_in;
  logic  div_zero;
  logic  ovf;
  word_t fast_res;

  always_comb begin
    a_sgn = bus.funct3 inside
      {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    b_sgn = bus.funct3 inside
      {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    sa = a_sgn & bus.op_a[WIDTH-1];
    sb = b_sgn & bus.op_b[WIDTH-1];
    mag_a = sa ? -bus.op_a : bus.op_a;
    mag_b = sb ? -bus.op_b : bus.op_b;
    // remainder follows the dividend sign only
    sign_in = (bus.funct3 == F3_REM) ? sa : (sa ^ sb);
    div_zero = bus.funct3[2] && (bus.op_b == '0);
    ovf = (bus.funct3 inside {F3_DIV, F3_REM})
      && (bus.op_a == SMIN) && (bus.op_b == '1);
    fast_res = '0;
    unique case (1'b1)
      div_zero && !bus.funct3[1]: fast_res = '1;
      div_zero && bus.funct3[1]:  fast_res = bus.op_a;
      ovf && !bus.funct3[1]:      fast_res = SMIN;
      default:                    fast_res = '0;
    endcase
  end

  logic [WIDTH:0] add;
  word_t          mul_hi;
  word_t          mul_lo;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           fits;
  word_t          div_hi;
  word_t          div_lo;

  always_comb begin
    add    = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
    mul_hi = add[WIDTH:1];
    mul_lo = {add[0], lo[WIDTH-1:1]};
    rem_sh = {hi, lo[WIDTH-1]};
    trial  = rem_sh - {1'b0, mb};
    fits   = !trial[WIDTH];
    div_hi = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_lo = {lo[WIDTH-2:0], fits};
  end

  logic [2*WIDTH-1:0] prod_fix;
  word_t              q_fix;
  word_t              r_fix;
  word_t              fix_res;

  always_comb begin
    prod_fix = neg ? -{hi, lo} : {hi, lo};
    q_fix    = neg ? -lo : lo;
    r_fix    = neg ? -hi : hi;
    fix_res  = '0;
    unique case (1'b1)
      f3 == F3_MUL:
        fix_res = prod_fix[WIDTH-1:0];
      !f3[2] && (f3 != F3_MUL):
        fix_res = prod_fix[2*WIDTH-1:WIDTH];
      f3[2] && !f3[1]:
        fix_res = q_fix;
      default:
        fix_res = r_fix;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      f3     <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      mb     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (bus.start) begin
            f3 <= bus.funct3;
            if (div_zero || ovf) begin
              res_q  <= fast_res;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              hi     <= '0;
              lo     <= mag_a;
              mb     <= mag_b;
              neg    <= sign_in;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (f3[2]) begin
            hi <= div_hi;
            lo <= div_lo;
          end else begin
            hi <= mul_hi;
            lo <= mul_lo;
          end
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= FIX;
          end
        end
        FIX: begin
          res_q  <= fix_res;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors,
// latency, fast path, start handling and async reset.
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dones = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done) begin
      dones++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, bus.result, e.res);
        check({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
        check({e.name, "_busy"}, {31'd0, bus.busy}, 32'd0);
      end
    end
  end

  // Call at a negedge; returns one negedge after the accept edge.
  task automatic issue(input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] res,
                       input bit fast,
                       input string name);
    exp_t e;
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    e.res  = res;
    e.lat  = fast ? 0 : 33;
    e.acc  = cyc + 1;
    e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.funct3 = 3'b011;
    bus.op_a   = 32'h5A5A_1234;
    bus.op_b   = 32'hDEAD_BEEF;
  endtask

  // Returns at the negedge where done is visible.
  task automatic wait_done(input bit fast, input string name);
    int  n = 0;
    bit  busy_bad = 1'b0;
    while (!bus.done && n < 40) begin
      if (!bus.busy) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(n < 40), 32'd1);
    if (!fast)
      check({name, "_busy_run"}, {31'd0, busy_bad}, 32'd0);
  endtask

  task automatic run_op(input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] res,
                        input bit fast,
                        input string name);
    issue(f, a, b, res, fast, name);
    wait_done(fast, name);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.start  = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul_7xm3");
    run_op(F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh_min");
    run_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_max");
    run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, "mulhsu_m1x2");
    run_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "div_m7_2");
    run_op(F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "rem_m7_2");
    run_op(F3_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, "div_7_m2");
    run_op(F3_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 0, "rem_7_m2");

    issue(F3_DIVU, 32'd100, 32'd7, 32'd14, 0, "divu_100_7");
    wait_done(0, "divu_100_7");
    issue(F3_REMU, 32'd100, 32'd7, 32'd2, 0, "remu_b2b");
    wait_done(0, "remu_b2b");
    @(negedge clk);

    run_op(F3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by0");
    run_op(F3_REMU, 32'd5, 32'd0, 32'd5, 1, "remu_by0");
    run_op(F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    run_op(F3_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, "rem_by0");
    run_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

    issue(F3_MUL, 32'd5, 32'd6, 32'd30, 0, "mul_ign");
    repeat (4) @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = F3_MUL;
    bus.op_a   = 32'd9;
    bus.op_b   = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(0, "mul_ign");
    repeat (3) @(negedge clk);

    issue(F3_MUL, 32'h1234, 32'h10, 32'h12340, 0, "mul_rst");
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    sb_q.delete();
    d0 = dones;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("no_done_after_rst", 32'(dones - d0), 32'd0);

    run_op(F3_MUL, 32'd3, 32'd4, 32'd12, 0, "mul_3x4");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
